// File: rtl/load_store_unit.sv
// Load/store unit sitting between the core's execute/memory stage and the
// data memory port. It takes one load or store per handshake and places the
// data in the correct byte lanes with matching byte enables. It sign- or
// zero-extends load data and rejects illegal or misaligned requests. It then
// waits for the memory acknowledge, with an optional timeout, and returns
// exactly one response per accepted request.
module load_store_unit #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN/8-1:0]     mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_ack,
    input  logic [XLEN-1:0]       mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Sizes that do not exist for this XLEN, the reserved code, and the
    // unsigned codes used as stores are all rejected.
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        case (f3)
            3'b011, 3'b110: bad = (XLEN == 32);
            3'b111:         bad = 1'b1;
            default:        bad = 1'b0;
        endcase
        if (we && f3[2]) bad = 1'b1;
        return bad;
    endfunction

    // funct3[1:0] encodes the access size as log2(bytes).
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] a);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = a[0];
            2'b10:   mis = |a[1:0];
            2'b11:   mis = |a;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte-enable pattern of an access sitting at lane 0.
    function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m[NB-1:0];
    endfunction

    // Expands byte enables into a bit mask over the data word.
    function automatic logic [XLEN-1:0] lane_bits(input logic [NB-1:0] be);
        logic [XLEN-1:0] bits;
        for (int i = 0; i < NB; i++) begin
            bits[8*i +: 8] = {8{be[i]}};
        end
        return bits;
    endfunction

    // Extends right-aligned load data; signed sources go through signed casts.
    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] raw);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        logic [XLEN-1:0]    ext;
        b = raw[7:0];
        h = raw[15:0];
        w = raw[31:0];
        case (f3)
            3'b000:  ext = XLEN'(b);
            3'b001:  ext = XLEN'(h);
            3'b010:  ext = XLEN'(w);
            3'b100:  ext = XLEN'(raw[7:0]);
            3'b101:  ext = XLEN'(raw[15:0]);
            3'b110:  ext = XLEN'(raw[31:0]);
            default: ext = raw;
        endcase
        return ext;
    endfunction

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [2:0]              f3_q, f3_d;
    logic [OFF_W-1:0]        off_q, off_d;
    logic                    mem_req_d, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [NB-1:0]           mem_be_d;
    logic [XLEN-1:0]         mem_wdata_d;
    logic                    resp_valid_d, resp_err_d;
    logic [XLEN-1:0]         resp_rdata_d;

    logic [OFF_W-1:0]        req_off;
    logic [NB-1:0]           req_mask;
    logic [NB-1:0]           req_be;
    logic [XLEN-1:0]         req_lanes;
    logic [XLEN-1:0]         load_val;
    logic                    timed_out;

    assign req_ready = (state_q == IDLE);
    assign req_off   = req_addr[OFF_W-1:0];
    assign req_mask  = size_mask(req_funct3[1:0]);
    assign req_be    = req_mask << req_off;
    assign req_lanes = (req_wdata & lane_bits(req_mask)) << {req_off, 3'b000};
    assign load_val  = extend(f3_q, mem_rdata >> {off_q, 3'b000});
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Next-state and next-output logic; the memory side is cleared whenever an access ends.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        f3_d         = f3_q;
        off_d        = off_q;
        mem_req_d    = mem_req;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_be_d     = mem_be;
        mem_wdata_d  = mem_wdata;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d  = req_we;
                    f3_d  = req_funct3;
                    off_d = req_off;
                    if (is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[2:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_we ? req_lanes : '0;
                    end
                end
            end
            ACCESS: begin
                // An acknowledge in the expiry cycle still completes normally.
                if (mem_ack || timed_out) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = !mem_ack;
                    resp_rdata_d = (mem_ack && !we_q) ? load_val : '0;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_be_d     = '0;
                    mem_wdata_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured request fields and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_be     <= mem_be_d;
            mem_wdata  <= mem_wdata_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32, TIMEOUT=4). A transaction-level
// model derives the expected memory-side fields and response from size/offset
// arithmetic; a per-cycle compare process checks the DUT against the expected
// waveform, and literal values pin the model on the key vectors.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    bit          chk_en = 1'b0;
    bit          exp_ready = 1'b1, exp_rv = 1'b0, exp_err = 1'b0, exp_mreq = 1'b0, exp_we = 1'b0;
    logic [31:0] exp_rdata = '0, exp_addr = '0, exp_wd = '0;
    logic [3:0]  exp_be = '0;
    int          total_req = 0, total_resp = 0;
    logic [31:0] cap_rdata = '0, cap_addr = '0, cap_wd = '0;
    logic [3:0]  cap_be = '0;
    logic        cap_err = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%h, expected 0x%h at %0t", nm, act, exp, $time);
    endtask

    task automatic set_idle();
        exp_ready = 1'b1; exp_rv = 1'b0; exp_err = 1'b0; exp_rdata = '0;
        exp_mreq = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wd = '0;
    endtask

    // Transaction model: size in bytes, lane offset, and numeric extension.
    function automatic void model(input bit we, input bit [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rd,
                                  output bit err, output logic [31:0] maddr, output logic [3:0] be,
                                  output logic [31:0] mwd, output logic [31:0] rdat);
        int     nbytes;
        int     off;
        longint lim;
        longint v;
        nbytes = 1 << f3[1:0];
        off    = int'(addr % 4);
        err    = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && f3 >= 4) || (addr % nbytes != 0);
        maddr = '0; be = '0; mwd = '0; rdat = '0;
        if (!err) begin
            lim   = longint'(1) << (8 * nbytes);
            maddr = addr - off;
            be    = 4'(((1 << nbytes) - 1) << off);
            if (we) begin
                mwd = 32'((longint'(wd) % lim) << (8 * off));
            end else begin
                v = (longint'(rd) >> (8 * off)) % lim;
                if (f3 < 4 && v >= lim / 2) v = v - lim;
                rdat = 32'(v);
            end
        end
    endfunction

    // One request; delay is the ACCESS cycle index of the ack (-1 = never).
    task automatic do_req(input bit we, input bit [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int delay, input logic [31:0] rd);
        bit          err, tmo;
        logic [31:0] maddr, mwd, rdat;
        logic [3:0]  be;
        model(we, f3, addr, wd, rd, err, maddr, be, mwd, rdat);
        tmo = (delay < 0) || (delay > TO - 1);
        set_idle();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        // junk request held while busy must be ignored
        req_we = !we; req_funct3 = 3'b000; req_addr = 32'hFFFF_FFF0; req_wdata = 32'h5A5A_5A5A;
        exp_ready = 1'b0;
        if (!err) begin
            for (int i = 0; i < TO; i++) begin
                exp_mreq = 1'b1; exp_we = we; exp_addr = maddr; exp_be = be; exp_wd = mwd;
                mem_ack   = (i == delay);
                mem_rdata = (i == delay) ? rd : (32'hDEAD_0000 | 32'(i));
                @(posedge clk); #1;
                mem_ack = 1'b0;
                if (i == delay) break;
            end
            exp_mreq = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wd = '0;
        end
        exp_rv = 1'b1; exp_err = err || tmo; exp_rdata = (err || tmo) ? 32'h0 : rdat;
        @(posedge clk); #1;
        req_valid = 1'b0;
        set_idle();
        @(posedge clk); #1;
    endtask

    initial begin
        int r0;
        fork
            forever begin
                @(negedge clk);
                if (mem_req) begin
                    total_req++;
                    cap_addr = mem_addr; cap_be = mem_be; cap_wd = mem_wdata;
                end
                if (resp_valid) begin
                    total_resp++;
                    cap_rdata = resp_rdata; cap_err = resp_err;
                end
                if (chk_en) begin
                    check("req_ready", req_ready, exp_ready);
                    check("resp_valid", resp_valid, exp_rv);
                    check("resp_err", resp_err, exp_err);
                    check("resp_rdata", resp_rdata, exp_rdata);
                    check("mem_req", mem_req, exp_mreq);
                    if (exp_mreq) begin
                        check("mem_we", mem_we, exp_we);
                        check("mem_addr", mem_addr, exp_addr);
                        check("mem_be", 32'(mem_be), 32'(exp_be));
                        check("mem_wdata", mem_wdata, exp_wd);
                    end
                end
            end
        join_none

        // reset values while rst is held
        @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", 32'(mem_be), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        chk_en = 1'b1;
        @(posedge clk); #1;

        // LB 0x103, zero-wait
        r0 = total_req;
        do_req(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_1234);
        check("lb_addr", cap_addr, 32'h100);
        check("lb_be", 32'(cap_be), 32'h8);
        check("lb_rdata", cap_rdata, 32'hFFFF_FF80);
        check("lb_err", cap_err, 0);
        check("lb_req_cycles", total_req - r0, 1);

        // SH 0x22
        do_req(1'b1, 3'b001, 32'h22, 32'h0000_ABCD, 0, 32'h1111_1111);
        check("sh_be", 32'(cap_be), 32'hC);
        check("sh_wdata", cap_wd, 32'hABCD_0000);
        check("sh_rdata", cap_rdata, 32'h0);

        // misaligned LW and illegal LD: no memory access
        r0 = total_req;
        do_req(1'b0, 3'b010, 32'h06, 32'h0, 0, 32'h0);
        check("lw_mis_err", cap_err, 1);
        do_req(1'b0, 3'b011, 32'h08, 32'h0, 0, 32'h0);
        check("ld_err", cap_err, 1);
        check("err_no_mem_req", total_req - r0, 0);

        // LHU 0x12, ack in the fourth ACCESS cycle (coincides with timeout expiry)
        r0 = total_req;
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 3, 32'h8001_5555);
        check("lhu_req_cycles", total_req - r0, 4);
        check("lhu_be", 32'(cap_be), 32'hC);
        check("lhu_rdata", cap_rdata, 32'h0000_8001);
        check("lhu_err", cap_err, 0);

        // timeout: LW 0x40, no ack
        r0 = total_req;
        do_req(1'b0, 3'b010, 32'h40, 32'h0, -1, 32'h0);
        check("tmo_req_cycles", total_req - r0, 4);
        check("tmo_err", cap_err, 1);

        // assorted directed vectors
        do_req(1'b1, 3'b000, 32'h05, 32'h1234_56AB, 1, 32'h0);
        check("sb_wdata", cap_wd, 32'h0000_AB00);
        do_req(1'b1, 3'b010, 32'h08, 32'hCAFE_BABE, 2, 32'h0);
        do_req(1'b0, 3'b010, 32'h0C, 32'h0, 2, 32'h89AB_CDEF);
        do_req(1'b0, 3'b001, 32'h00, 32'h0, 0, 32'h0000_F00F);
        check("lh_rdata", cap_rdata, 32'hFFFF_F00F);
        do_req(1'b0, 3'b001, 32'h02, 32'h0, 1, 32'h7FFF_0000);
        do_req(1'b0, 3'b000, 32'h00, 32'h0, 0, 32'h0000_007F);
        do_req(1'b1, 3'b100, 32'h00, 32'hFF, 0, 32'h0);
        do_req(1'b0, 3'b111, 32'h00, 32'h0, 0, 32'h0);
        do_req(1'b1, 3'b001, 32'h03, 32'h1234, 0, 32'h0);

        // reset in the middle of an access
        set_idle();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_ready = 1'b0; exp_mreq = 1'b1; exp_we = 1'b0; exp_addr = 32'h80; exp_be = 4'hF; exp_wd = '0;
        @(negedge clk); #1;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_ready", req_ready, 1);
        check("arst_mem_be", 32'(mem_be), 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_resp_valid", resp_valid, 0);
        r0 = total_resp;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("late_ack_no_resp", total_resp - r0, 0);
        check("late_ack_ready", req_ready, 1);
        set_idle();
        chk_en = 1'b1;

        // LBU 0x1 after reset
        do_req(1'b0, 3'b100, 32'h01, 32'h0, 0, 32'h0000_F000);
        check("lbu_rdata", cap_rdata, 32'h0000_00F0);
        check("lbu_be", 32'(cap_be), 32'h2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
